// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART console path: ASCII control
// characters, the message-formatter state encoding and default clock/baud.
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned CLK_FRE   = 27;        // board clock, MHz
   localparam int unsigned UART_BAUD = 115200;

   localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0d;
   localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0a;

   // Message formatter states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } hex_state_e;

endpackage

// File: rtl/hex_nibble_ascii.sv
// ----------------------------------------------------------------------------
// hex_nibble_ascii
// Combinational 4-bit nibble to lowercase ASCII hex character ('0'..'9',
// 'a'..'f').
// Ports:
//   nibble   in  4  value to encode
//   ascii_c  out 8  ASCII character (combinational)
// ----------------------------------------------------------------------------
module hex_nibble_ascii
   import uart_pkg::*;
(
   input  logic [3:0]        nibble,
   output logic [BYTE_W-1:0] ascii_c
);

   // 8'h57 + 10 = 'a'
   always_comb begin
      if (nibble < 4'd10) begin
         ascii_c = 8'h30 + {4'h0, nibble};
      end else begin
         ascii_c = 8'h57 + {4'h0, nibble};
      end
   end

endmodule

// File: rtl/uart_hex_report.sv
// ----------------------------------------------------------------------------
// uart_hex_report
// On a request, captures a value and streams PREFIX, the value as lowercase
// ASCII hex (MSB nibble first) and CR LF into uart_tx, one byte per
// valid/ready handshake with a one-cycle gap after every accepted byte.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req             start request, sampled only while idle
//   value           value to print, captured with the accepted request
//   busy            message in progress
//   done            one-cycle pulse after the final LF byte is accepted
//   tx_data         byte to uart_tx (registered)
//   tx_data_valid   byte valid to uart_tx (registered)
//   tx_data_ready   uart_tx can accept a byte
// ----------------------------------------------------------------------------
module uart_hex_report
   import uart_pkg::*;
#(
   parameter int unsigned PREFIX_LEN = 4,
   parameter logic [((PREFIX_LEN > 0) ? PREFIX_LEN : 1)*8-1:0] PREFIX = "cnt=",
   parameter int unsigned HEX_DIGITS = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req,
   input  logic [4*HEX_DIGITS-1:0] value,
   output logic                    busy,
   output logic                    done,
   output logic [BYTE_W-1:0]       tx_data,
   output logic                    tx_data_valid,
   input  logic                    tx_data_ready
);

   localparam int unsigned VAL_W   = 4 * HEX_DIGITS;
   localparam int unsigned IDX_W   = 8;
   localparam int unsigned MSG_LEN = PREFIX_LEN + HEX_DIGITS + 2;

   // Parameter legality
   if (MSG_LEN > 255) begin : g_len_chk
      $error("uart_hex_report: message length must not exceed 255 bytes");
   end
   if (HEX_DIGITS < 1 || HEX_DIGITS > 8) begin : g_dig_chk
      $error("uart_hex_report: HEX_DIGITS must be 1..8");
   end

   hex_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [VAL_W-1:0]  val_q, val_d;

   logic              busy_d, done_d, valid_d;
   logic [BYTE_W-1:0] data_d;

   logic              accept;
   logic              last;
   logic [3:0]        nibble;
   logic              is_hex;
   logic [BYTE_W-1:0] const_byte;
   logic [BYTE_W-1:0] hex_c;

   assign accept = (state_q == ST_SEND) && tx_data_valid && tx_data_ready;
   assign last   = (idx_q == IDX_W'(MSG_LEN - 1));

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         val_q         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         tx_data       <= '0;
         tx_data_valid <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         val_q         <= val_d;
         busy          <= busy_d;
         done          <= done_d;
         tx_data       <= data_d;
         tx_data_valid <= valid_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      val_d   = val_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               val_d   = value;
               idx_d   = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (accept) begin
               if (last) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            state_d = ST_SEND;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Byte decode for the upcoming index: prefix, hex nibble or CR/LF
   always_comb begin
      const_byte = ASCII_LF;
      nibble     = 4'h0;
      is_hex     = 1'b0;
      if (idx_d == IDX_W'(MSG_LEN - 2)) begin
         const_byte = ASCII_CR;
      end
      for (int k = 0; k < int'(PREFIX_LEN); k++) begin
         if (idx_d == IDX_W'(k)) begin
            const_byte = PREFIX[8*(int'(PREFIX_LEN)-1-k) +: 8];
         end
      end
      for (int k = 0; k < int'(HEX_DIGITS); k++) begin
         if (idx_d == IDX_W'(int'(PREFIX_LEN) + k)) begin
            is_hex = 1'b1;
            nibble = val_d[4*(int'(HEX_DIGITS)-1-k) +: 4];
         end
      end
   end

   hex_nibble_ascii u_hex (
      .nibble  (nibble),
      .ascii_c (hex_c)
   );

   // Output logic: values registered at the next edge
   always_comb begin
      busy_d  = (state_d != ST_IDLE);
      done_d  = accept && last;
      valid_d = (state_d == ST_SEND);
      data_d  = tx_data;
      if (valid_d) begin
         data_d = is_hex ? hex_c : const_byte;
      end
   end

endmodule

// File: tb/tb_uart_hex_report.sv
// ----------------------------------------------------------------------------
// tb_uart_hex_report
// Scoreboard bench for uart_hex_report with three configurations:
//   dut0: "cnt=" prefix, 2 hex digits
//   dut1: no prefix, 8 hex digits
//   dut2: no prefix, 1 hex digit
// ----------------------------------------------------------------------------
module tb_uart_hex_report;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req, rdy, busy, done, vld;
   logic [7:0]  value0;
   logic [31:0] value1;
   logic [3:0]  value2;
   logic [7:0]  data0, data1, data2;

   always #5 clk = ~clk;

   uart_hex_report #(.PREFIX_LEN(4), .PREFIX("cnt="), .HEX_DIGITS(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req[0]), .value(value0),
      .busy(busy[0]), .done(done[0]), .tx_data(data0),
      .tx_data_valid(vld[0]), .tx_data_ready(rdy[0]));

   uart_hex_report #(.PREFIX_LEN(0), .PREFIX(8'h00), .HEX_DIGITS(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req[1]), .value(value1),
      .busy(busy[1]), .done(done[1]), .tx_data(data1),
      .tx_data_valid(vld[1]), .tx_data_ready(rdy[1]));

   uart_hex_report #(.PREFIX_LEN(0), .PREFIX(8'h00), .HEX_DIGITS(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .req(req[2]), .value(value2),
      .busy(busy[2]), .done(done[2]), .tx_data(data2),
      .tx_data_valid(vld[2]), .tx_data_ready(rdy[2]));

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t q[3][$];
   int   phase[3];
   int   done_cnt[3];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected bytes of one message: text, then CR, then LF (last)
   task automatic push_msg(input int id, input string s);
      exp_t e;
      for (int i = 0; i < s.len(); i++) begin
         e.data = s[i];
         e.last = 1'b0;
         q[id].push_back(e);
      end
      e.data = 8'h0d; e.last = 1'b0; q[id].push_back(e);
      e.data = 8'h0a; e.last = 1'b1; q[id].push_back(e);
   endtask

   // phase: 1 = expect gap cycle, 2 = expect valid back, 3 = expect done pulse
   task automatic mon_step(input int id, input logic v, input logic b, input logic d,
                           input logic [7:0] data);
      exp_t e;
      bit   exp_done;
      if (!rst_n) begin
         phase[id] = 0;
         return;
      end
      exp_done = (phase[id] == 3);
      case (phase[id])
         1: begin check($sformatf("gap%0d", id), 32'(v), 32'h0); phase[id] = 2; end
         2: begin check($sformatf("resume%0d", id), 32'(v), 32'h1); phase[id] = 0; end
         3: begin check($sformatf("done_busy%0d", id), 32'({d, b}), 32'h2); phase[id] = 0; end
         default: ;
      endcase
      if (d) done_cnt[id]++;
      if (d && !exp_done) check($sformatf("spurious_done%0d", id), 32'(d), 32'h0);
      if (v && rdy[id]) begin
         if (q[id].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte%0d: got %0h, expected no byte", id, data);
         end else begin
            e = q[id].pop_front();
            check($sformatf("byte%0d", id), 32'(data), 32'(e.data));
            phase[id] = e.last ? 3 : 1;
         end
      end
   endtask

   always @(negedge clk) begin
      mon_step(0, vld[0], busy[0], done[0], data0);
      mon_step(1, vld[1], busy[1], done[1], data1);
      mon_step(2, vld[2], busy[2], done[2], data2);
   end

   task automatic send_req(input int id, input logic [31:0] v);
      @(posedge clk); #1;
      req[id] = 1'b1;
      case (id)
         0:       value0 = v[7:0];
         1:       value1 = v;
         default: value2 = v[3:0];
      endcase
      @(posedge clk); #1;
      req[id] = 1'b0;
   endtask

   task automatic wait_done(input int id, input int target, input int budget);
      int n = 0;
      while (done_cnt[id] < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("done_reached%0d", id), 32'(done_cnt[id] >= target), 32'h1);
   endtask

   // Wait at a falling edge until dut0 presents the given byte
   task automatic sync_byte0(input logic [7:0] b, input string name);
      bit found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(negedge clk);
         if (vld[0] && data0 == b) found = 1'b1;
      end
      check(name, 32'(found), 32'h1);
   endtask

   initial begin
      bit         found, stable;
      logic [7:0] hd;
      logic       hv;
      int         nd, cyc, c1, c2;

      rst_n  = 1'b0;
      req    = '0;
      rdy    = 3'b111;
      value0 = '0;
      value1 = '0;
      value2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",  32'(busy[0]), 32'h0);
      check("rst_done",  32'(done[0]), 32'h0);
      check("rst_valid", 32'(vld),     32'h0);
      check("rst_data",  32'(data0),   32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Basic message: 63 6e 74 3d 33 61 0d 0a
      push_msg(0, "cnt=3a");
      send_req(0, 32'h3a);
      wait_done(0, 1, 100);
      check("t1_empty", 32'(q[0].size()), 32'h0);

      // Full-width lowercase digits, leading zeros
      push_msg(1, "deadbeef");
      send_req(1, 32'hdeadbeef);
      wait_done(1, 1, 200);
      push_msg(1, "00000000");
      send_req(1, 32'h0);
      wait_done(1, 2, 200);
      check("t2_empty", 32'(q[1].size()), 32'h0);

      // Backpressure on the 5th byte ('3')
      push_msg(0, "cnt=3a");
      send_req(0, 32'h3a);
      sync_byte0(8'h3d, "t3_sync");
      @(posedge clk); #1;
      rdy[0] = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         @(negedge clk);
         if (vld[0]) found = 1'b1;
      end
      hd = data0;
      hv = vld[0];
      stable = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (data0 !== hd || vld[0] !== hv) stable = 1'b0;
      end
      check("t3_hold_byte",  32'(hd),     32'h33);
      check("t3_hold_valid", 32'(hv),     32'h1);
      check("t3_stable",     32'(stable), 32'h1);
      @(posedge clk); #1;
      rdy[0] = 1'b1;
      wait_done(0, 2, 100);

      // Request and value change while busy are ignored
      push_msg(0, "cnt=3a");
      send_req(0, 32'h3a);
      repeat (5) @(posedge clk);
      #1;
      req[0] = 1'b1;
      value0 = 8'h55;
      @(posedge clk); #1;
      req[0] = 1'b0;
      wait_done(0, 3, 100);
      repeat (20) @(negedge clk);
      check("t4_empty", 32'(q[0].size()), 32'h0);
      check("t4_dones", 32'(done_cnt[0]), 32'h3);
      push_msg(0, "cnt=55");
      send_req(0, 32'h55);
      wait_done(0, 4, 100);

      // Reset during the 3rd byte abandons the message
      push_msg(0, "cnt=3a");
      send_req(0, 32'h3a);
      sync_byte0(8'h74, "t5_sync");
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_busy",  32'(busy[0]), 32'h0);
      check("t5_done",  32'(done[0]), 32'h0);
      check("t5_valid", 32'(vld[0]),  32'h0);
      check("t5_data",  32'(data0),   32'h0);
      q[0].delete();
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      push_msg(0, "cnt=3a");
      send_req(0, 32'h3a);
      wait_done(0, 5, 100);
      check("t5_empty", 32'(q[0].size()), 32'h0);

      // Held request: back-to-back "f\r\n" messages, 6 cycles apart
      push_msg(2, "f");
      push_msg(2, "f");
      push_msg(2, "f");
      @(posedge clk); #1;
      value2 = 4'hf;
      req[2] = 1'b1;
      nd = 0; cyc = 0; c1 = 0; c2 = 0;
      for (int n = 0; n < 200 && nd < 3; n++) begin
         @(negedge clk);
         cyc++;
         if (done[2]) begin
            nd++;
            if (nd == 1) c1 = cyc;
            if (nd == 2) c2 = cyc;
            if (nd == 3) begin
               #1;
               req[2] = 1'b0;
            end
         end
      end
      check("t6_period", 32'(c2 - c1), 32'h6);
      repeat (10) @(negedge clk);
      check("t6_empty", 32'(q[2].size()), 32'h0);
      check("t6_dones", 32'(done_cnt[2]), 32'h3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/uart_hex_report.md
# uart_hex_report

Transmit-side message formatter for the UART console path. On a single request it captures a binary value and streams `PREFIX`, the value as lowercase ASCII hex (MSB nibble first), and a CR LF terminator, one byte at a time, into `uart_tx` over its valid/ready handshake. It is the sending counterpart to the line-receive/echo logic and replaces the hand-built "cnt=XX" byte strings with one reusable block.

## Interface
- `PREFIX_LEN`, 4: number of prefix bytes; 0 allowed (no prefix).
- `PREFIX`, "cnt=": prefix string, `PREFIX_LEN*8` bits, first character in the most significant byte.
- `HEX_DIGITS`, 8: number of hex digits emitted, 1..8.
- `clk`  in  1  system clock (27 MHz board clock).
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  start request; sampled only while idle.
- `value`  in  `4*HEX_DIGITS`  value to print; captured on the accepted request.
- `busy`  out  1  high from the cycle after an accepted request until the final byte is accepted.
- `done`  out  1  single-cycle pulse when the final LF byte is accepted.
- `tx_data`  out  8  byte to `uart_tx`.
- `tx_data_valid`  out  1  byte valid to `uart_tx`.
- `tx_data_ready`  in  1  `uart_tx` can accept a byte.

## Operation
- Reset values: `busy`=0, `done`=0, `tx_data`=8'h00, `tx_data_valid`=0; state IDLE; byte index 0; value register 0.
- Message length N = `PREFIX_LEN + HEX_DIGITS + 2`. Index i: i < `PREFIX_LEN` -> prefix byte i. Next `HEX_DIGITS` indices -> hex digits, MSB nibble first. Then 8'h0d, then 8'h0a.
- Hex encoding: nibble n < 10 -> 8'h30+n; n ≥ 10 -> 8'h57+n ('a'..'f'). Leading zeros are always printed.
- States:
  - IDLE: when `req`=1, capture `value`, set index 0, go to SEND. `done` low.
  - SEND: drive byte[index] with `tx_data_valid`=1. Byte is accepted in a cycle where `tx_data_valid`&&`tx_data_ready`. On accept: if index = N-1, go to IDLE and pulse `done`. Otherwise index+1, go to GAP.
  - GAP: `tx_data_valid`=0 for exactly one cycle, then SEND. This gap covers `uart_tx` dropping ready one cycle after accept.
- Byte index is 8 bits. N ≤ 255 is a parameter legality rule; checked by an elaboration-time error.
- `req` while busy is ignored, not queued. `value` changes while busy have no effect.
- `req` held high continuously: a new message starts in the IDLE cycle after `done`, so messages go back-to-back.
- Backpressure: while in SEND with `tx_data_ready`=0, `tx_data` and `tx_data_valid` hold stable indefinitely. No timeout.
- Reset mid-message: the message is abandoned and all outputs return to reset values asynchronously. No partial resume. `uart_tx` shares `rst_n`.

## Timing
- `req` high at edge k (IDLE) -> `busy`=1, `tx_data_valid`=1 with the first byte after edge k.
- Accept at edge t -> `tx_data_valid`=0 after t, next byte valid after t+1. Minimum 2 cycles per byte. Throughput is bounded by UART baud, not by this block.
- Final accept at edge t -> `done`=1 and `busy`=0 for the cycle after t. `done` falls after t+1.
- `tx_data` is registered. No combinational path from `tx_data_ready` to any output.

## Structure
- Shared package `uart_pkg`:
  - `ASCII_CR` (8'h0d), `ASCII_LF` (8'h0a).
  - State encodings IDLE/SEND/GAP.
  - `CLK_FRE` and `UART_BAUD` defaults.
- Sub-module `hex_nibble_ascii`: combinational 4-bit to ASCII byte. Reused by any other block that prints hex.
- Byte select is a mux on index range: prefix slice, nibble slice of the captured value via `hex_nibble_ascii`, or CR/LF constant.

## Test plan
- `PREFIX`="cnt=", `HEX_DIGITS`=2, `value`=8'h3a, ready always high -> bytes 63 6e 74 3d 33 61 0d 0a, in order. One `done` pulse. Each byte is separated by exactly one invalid cycle.
- `HEX_DIGITS`=8, `value`=32'hdeadbeef, then 32'h00000000 -> "deadbeef\r\n" then "00000000\r\n". All 8 digits printed, lowercase.
- Ready held low 100 cycles while on the 5th byte -> `tx_data` and `tx_data_valid` stable throughout. Sequence resumes unchanged when ready returns.
- Second `req` pulse plus a `value` change mid-message -> the first message is unaffected and no second message is sent. A later `req` in IDLE sends the new value.
- `rst_n` low during the 3rd byte -> outputs reset immediately. A post-reset `req` sends the full message from byte 0.
- `PREFIX_LEN`=0, `HEX_DIGITS`=1, `value`=4'hf -> bytes 66 0d 0a. `req` held high -> back-to-back repeats, one `done` per message.
